// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states, error codes and instruction field offsets
// for the ALU issue controller.
package alu_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ILL  = 2'b01;
    localparam logic [1:0] ERR_DIV0 = 2'b10;

    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 7;
    localparam int RS2_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPRD = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DATA_W register file with two operand reads, one debug read
// and one write port; optionally hardwires R0 to zero.
module alu_regfile #(
    parameter int DATA_W  = 16,
    parameter int NREG    = 8,
    parameter bit R0_ZERO = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra_addr,
    input  logic [AW-1:0]     rb_addr,
    input  logic [AW-1:0]     dbg_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && !(R0_ZERO && wr_addr == '0)) regs_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end

    assign ra_data  = (R0_ZERO && ra_addr == '0)  ? '0 : regs_q[ra_addr];
    assign rb_data  = (R0_ZERO && rb_addr == '0)  ? '0 : regs_q[rb_addr];
    assign dbg_data = (R0_ZERO && dbg_addr == '0) ? '0 : regs_q[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one 3-operand instruction every 4 cycles to an external
// combinational ALU, guarding against illegal opcodes and divide-by-zero.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NREG    = 8,
    parameter bit R0_ZERO = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              flag_z,
    output logic              alu_chk_err,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_t                  state_q, state_d;
    logic [15:RS2_LSB]       instr_q, instr_d;
    logic [DATA_W-1:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
    logic [2:0]              alu_op_q, alu_op_d;
    logic [1:0]              code_q, code_d;
    logic                    z_q, z_d, flag_z_q, flag_z_d, chk_q, chk_d;
    logic [DATA_W-1:0]       ra_data, rb_data;
    logic                    wb_ok;
    logic                    unused_low_bits;

    wire [2:0] op = instr_q[OP_LSB +: 3];

    assign unused_low_bits = ^instr[RS2_LSB-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = instr_valid ? S_OPRD : S_IDLE;
            S_OPRD:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = state_q == S_IDLE;
        done        = state_q == S_WB;
        err         = done && code_q != ERR_NONE;
        err_code    = done ? code_q : ERR_NONE;
    end

    always_comb begin
        instr_d  = (state_q == S_IDLE && instr_valid) ? instr[15:RS2_LSB] : instr_q;
        alu_a_d  = (state_q == S_OPRD) ? ra_data : alu_a_q;
        alu_b_d  = (state_q == S_OPRD) ? rb_data : alu_b_q;
        alu_op_d = (state_q == S_OPRD && op != OP_ILL) ? op : alu_op_q;
        code_d   = (state_q != S_OPRD)                ? code_q   :
                   (op == OP_ILL)                     ? ERR_ILL  :
                   (op == OP_DIV && rb_data == '0)    ? ERR_DIV0 : ERR_NONE;
        res_d    = (state_q == S_EXEC) ? alu_result : res_q;
        z_d      = (state_q == S_EXEC) ? alu_zero : z_q;
        wb_ok    = state_q == S_WB && code_q == ERR_NONE;
        flag_z_d = wb_ok ? (res_q == '0) : flag_z_q;
        // cross-check the ALU's own zero output against the captured result
        chk_d    = chk_q | (wb_ok && (z_q != (res_q == '0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            code_q   <= ERR_NONE;
            res_q    <= '0;
            z_q      <= 1'b0;
            flag_z_q <= 1'b0;
            chk_q    <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            code_q   <= code_d;
            res_q    <= res_d;
            z_q      <= z_d;
            flag_z_q <= flag_z_d;
            chk_q    <= chk_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_op_q;
    assign flag_z      = flag_z_q;
    assign alu_chk_err = chk_q;

    alu_regfile #(.DATA_W(DATA_W), .NREG(NREG), .R0_ZERO(R0_ZERO)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (instr_q[RS1_LSB +: AW]),
        .rb_addr  (instr_q[RS2_LSB +: AW]),
        .dbg_addr (dbg_addr),
        .wr_en    (wb_ok),
        .wr_addr  (instr_q[RD_LSB +: AW]),
        .wr_data  (res_q),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data)
    );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives a table of instructions through the controller and a
// behavioural 16-bit ALU, scoreboarding retire status and architectural state.
module tb_alu_issue_ctrl;
    logic        clk, rst_n, instr_valid, instr_ready;
    logic [15:0] instr, alu_a, alu_b, alu_result, dbg_data;
    logic [2:0]  alu_opcode, dbg_addr;
    logic        alu_zero, done, err, flag_z, alu_chk_err;
    logic [1:0]  err_code;

    typedef struct {
        logic [2:0]  op, rd, rs1, rs2;
        logic [15:0] val;
        logic        z;
        logic [1:0]  code;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    logic [2:0] last_op = 3'd0;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .done(done), .err(err),
        .err_code(err_code), .flag_z(flag_z), .alu_chk_err(alu_chk_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return p[15:0];
            3'd3:    return (b == 16'd0) ? 16'hFFFF : a / b;
            3'd4:    return a | b;
            3'd5:    return ~(a | b);
            3'd6:    return ~(a & b);
            default: return 16'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_opcode, alu_a, alu_b);
    assign alu_zero   = alu_result == 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, rd, rs1, rs2, input logic [15:0] val, input logic z, input logic [1:0] code);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.val = val; v.z = z; v.code = code;
        tbl.push_back(v);
    endtask

    // Entered and left on a falling edge; expected results ride the scoreboard until done.
    task automatic issue(input int idx, input vec_t v);
        vec_t e;
        int   cyc;
        logic [2:0] eop;
        instr       = {v.op, v.rd, v.rs1, v.rs2, 4'($urandom)};
        instr_valid = 1'b1;
        dbg_addr    = v.rd;
        sb.push_back(v);
        eop     = (v.op == 3'b111) ? last_op : v.op;
        last_op = eop;
        chk($sformatf("v%0d ready_idle", idx), 32'(instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        chk($sformatf("v%0d ready_busy", idx), 32'(instr_ready), 32'd0);
        cyc = 2;
        while (!done && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'd4);
        if (done) begin
            if (sb.size() == 0) chk($sformatf("v%0d sb_nonempty", idx), 32'd0, 32'd1);
            else begin
                e = sb.pop_front();
                chk($sformatf("v%0d err", idx), 32'(err), 32'(e.code != 2'b00));
                chk($sformatf("v%0d err_code", idx), 32'(err_code), 32'(e.code));
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d ready_back", idx), 32'(instr_ready), 32'd1);
        chk($sformatf("v%0d reg", idx), 32'(dbg_data), 32'(v.val));
        chk($sformatf("v%0d flag_z", idx), 32'(flag_z), 32'(v.z));
        chk($sformatf("v%0d alu_opcode", idx), 32'(alu_opcode), 32'(eop));
        chk($sformatf("v%0d chk_err", idx), 32'(alu_chk_err), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " err_code"}, 32'(err_code), 32'd0);
        chk({tag, " alu_a"}, 32'(alu_a), 32'd0);
        chk({tag, " alu_b"}, 32'(alu_b), 32'd0);
        chk({tag, " alu_opcode"}, 32'(alu_opcode), 32'd0);
        chk({tag, " flag_z"}, 32'(flag_z), 32'd0);
        chk({tag, " chk_err"}, 32'(alu_chk_err), 32'd0);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk($sformatf("%s R%0d", tag, r), 32'(dbg_data), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        // op, rd, rs1, rs2, expected rd value afterwards, expected flag_z, expected err_code
        add(3'd5, 3'd7, 3'd0, 3'd0, 16'hFFFF, 1'b0, 2'd0);
        add(3'd1, 3'd1, 3'd0, 3'd7, 16'h0001, 1'b0, 2'd0);
        add(3'd0, 3'd2, 3'd1, 3'd1, 16'h0002, 1'b0, 2'd0);
        add(3'd0, 3'd3, 3'd2, 3'd1, 16'h0003, 1'b0, 2'd0);
        add(3'd0, 3'd4, 3'd2, 3'd2, 16'h0004, 1'b0, 2'd0);
        add(3'd0, 3'd5, 3'd4, 3'd1, 16'h0005, 1'b0, 2'd0);
        add(3'd0, 3'd6, 3'd3, 3'd4, 16'h0007, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd5, 3'd0, 16'h0005, 1'b0, 2'd0);
        add(3'd0, 3'd2, 3'd6, 3'd0, 16'h0007, 1'b0, 2'd0);
        add(3'd0, 3'd3, 3'd1, 3'd2, 16'h000C, 1'b0, 2'd0);
        add(3'd2, 3'd6, 3'd3, 3'd4, 16'h0030, 1'b0, 2'd0);
        add(3'd0, 3'd6, 3'd6, 3'd4, 16'h0034, 1'b0, 2'd0);
        add(3'd0, 3'd5, 3'd3, 3'd2, 16'h0013, 1'b0, 2'd0);
        add(3'd0, 3'd5, 3'd5, 3'd7, 16'h0012, 1'b0, 2'd0);
        add(3'd2, 3'd4, 3'd4, 3'd4, 16'h0010, 1'b0, 2'd0);
        add(3'd2, 3'd4, 3'd4, 3'd4, 16'h0100, 1'b0, 2'd0);
        add(3'd2, 3'd5, 3'd5, 3'd4, 16'h1200, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd5, 3'd6, 16'h1234, 1'b0, 2'd0);
        add(3'd0, 3'd6, 3'd4, 3'd0, 16'h0100, 1'b0, 2'd0);
        add(3'd2, 3'd2, 3'd4, 3'd4, 16'h0000, 1'b1, 2'd0);
        add(3'd1, 3'd4, 3'd1, 3'd1, 16'h0000, 1'b1, 2'd0);
        add(3'd3, 3'd5, 3'd1, 3'd2, 16'h1200, 1'b1, 2'd2);
        add(3'd3, 3'd3, 3'd1, 3'd3, 16'h0184, 1'b0, 2'd0);
        add(3'd7, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 2'd1);
        add(3'd4, 3'd2, 3'd5, 3'd6, 16'h1300, 1'b0, 2'd0);
        add(3'd6, 3'd4, 3'd3, 3'd7, 16'hFE7B, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd6, 3'd6, 16'h0200, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd1, 3'd1, 16'h0400, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd1, 3'd1, 16'h0800, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd1, 3'd1, 16'h1000, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd1, 3'd1, 16'h2000, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd1, 3'd1, 16'h4000, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd1, 3'd1, 16'h8000, 1'b0, 2'd0);
        add(3'd0, 3'd1, 3'd1, 3'd1, 16'h0000, 1'b1, 2'd0);
        add(3'd0, 3'd0, 3'd7, 3'd7, 16'h0000, 1'b0, 2'd0);
        add(3'd5, 3'd2, 3'd1, 3'd4, 16'h0184, 1'b0, 2'd0);

        rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0; dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset ready", 32'(instr_ready), 32'd1);

        foreach (tbl[i]) issue(i, tbl[i]);

        // Abort an instruction in EXEC: no done, everything cleared.
        instr = {3'd0, 3'd3, 3'd4, 3'd2, 4'h0};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        chk("abort done_low", 32'(done), 32'd0);
        rst_n = 1'b1;
        last_op = 3'd0;
        @(negedge clk);
        chk("abort ready", 32'(instr_ready), 32'd1);
        v.op = 3'd5; v.rd = 3'd7; v.rs1 = 3'd0; v.rs2 = 3'd0; v.val = 16'hFFFF; v.z = 1'b0; v.code = 2'd0;
        issue(100, v);
        v.op = 3'd0; v.rd = 3'd3; v.rs1 = 3'd7; v.rs2 = 3'd7; v.val = 16'hFFFE; v.z = 1'b0; v.code = 2'd0;
        issue(101, v);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
